// File: rtl/mul_issuer.sv
// mul_issuer: command FIFO and issue control in front of the Booth multiplier, plus an
// in-order tagged result stage. Define MUL_ISSUER_CHECK_EN to build the sticky err checker.
module mul_issuer #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    // upstream command channel
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic             cmd_signed,
    // multiplier operand channel
    output logic             mul_valid,
    input  logic             mul_ready,
    output logic [31:0]      mul_data1,
    output logic [31:0]      mul_data2,
    output logic             mul_signal,
    // multiplier result channel
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [63:0]      res_data,
    // downstream result channel
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_res,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       outstanding,
    output logic             err
);
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sgn;
    } cmd_t;

    cmd_t             fifo_mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic [PTR_W-1:0] head_idx;
    cmd_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             issue_hs;
    logic             retire_hs;
    logic [TAG_W-1:0] retire_tag;

    // The issue-side tag is always retire_tag + outstanding because results come back in
    // order, so only the retire side is stored.

    // NOTE: continuous assigns / always_comb for pure logic, non-blocking <= only inside
    // always_ff, so every register samples pre-edge values regardless of block ordering.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    // When empty, point at the entry just popped so the operand outputs hold their last value.
    assign head_idx   = fifo_empty ? (rd_ptr[PTR_W-1:0] - PTR_W'(1)) : rd_ptr[PTR_W-1:0];
    assign head       = fifo_mem[head_idx];

    assign mul_valid  = !fifo_empty && (outstanding < 4'(MAX_OUT));
    assign mul_data1  = head.b;
    assign mul_data2  = head.a;
    assign mul_signal = head.sgn;
    assign issue_hs   = mul_valid && mul_ready;

    assign res_ready  = !out_valid || out_ready;
    assign retire_hs  = res_valid && res_ready;

    // NOTE: the storage is only DEPTH entries, so it is reset along with the pointers;
    // that keeps the operand outputs defined straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr <= '0;
        end else if (push) begin
            fifo_mem[wr_ptr[PTR_W-1:0]] <= '{a: cmd_a, b: cmd_b, sgn: cmd_signed};
            wr_ptr                      <= wr_ptr + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
        end else if (issue_hs) begin
            rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // A simultaneous issue and retire leaves the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_hs, retire_hs})
                2'b10:   outstanding <= outstanding + 4'd1;
                2'b01:   outstanding <= outstanding - 4'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_res    <= '0;
            out_tag    <= '0;
            retire_tag <= '0;
        end else if (retire_hs) begin
            out_valid  <= 1'b1;
            out_res    <= res_data;
            out_tag    <= retire_tag;
            retire_tag <= retire_tag + TAG_W'(1);
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

`ifdef MUL_ISSUER_CHECK_EN
    logic issue_waiting;

    // A request that was waiting last cycle must still be up unless it handshook.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_waiting <= 1'b0;
            err           <= 1'b0;
        end else begin
            issue_waiting <= mul_valid && !mul_ready;
            if ((res_valid && (outstanding == 4'd0)) || (issue_waiting && !mul_valid)) begin
                err <= 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mul_issuer.sv
// Directed self-checking bench for mul_issuer: reset, issue/retire, backpressure on both
// channels, outstanding cap, tag wrap and asynchronous reset mid-stream.
`timescale 1ns/1ps
module tb_mul_issuer;
    localparam int TAG_W = 4;
`ifdef MUL_ISSUER_CHECK_EN
    localparam logic CHECK_EN = 1'b1;
`else
    localparam logic CHECK_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic             cmd_signed;
    logic             mul_valid;
    logic             mul_ready;
    logic [31:0]      mul_data1;
    logic [31:0]      mul_data2;
    logic             mul_signal;
    logic             res_valid;
    logic             res_ready;
    logic [63:0]      res_data;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_res;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       outstanding;
    logic             err;

    int checks    = 0;
    int errors    = 0;
    int issue_cnt = 0;

    mul_issuer #(.DEPTH(4), .MAX_OUT(2), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_signed(cmd_signed),
        .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_data1(mul_data1),
        .mul_data2(mul_data2), .mul_signal(mul_signal),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_tag(out_tag),
        .outstanding(outstanding), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mul_valid && mul_ready) issue_cnt <= issue_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cmd_valid = 1'b0; mul_ready = 1'b0; res_valid = 1'b0; out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b,
                                         input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, mul_valid, res_ready, out_valid} !== 4'b1010) begin
            errors++;
            $display("FAIL reset_handshakes: got %b expected 1010",
                     {cmd_ready, mul_valid, res_ready, out_valid});
        end
        checks++;
        if (out_res !== 64'd0 || out_tag !== '0) begin
            errors++;
            $display("FAIL reset_result: got res=%h tag=%0d expected 0/0", out_res, out_tag);
        end
        checks++;
        if (outstanding !== 4'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_counters: got outstanding=%0d err=%b expected 0/0",
                     outstanding, err);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (mul_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_idle: got mul_valid=%b cmd_ready=%b expected 0/1",
                     mul_valid, cmd_ready);
        end
    endtask

    task automatic test_single_op();
        out_ready = 1'b1; mul_ready = 1'b0;
        cmd_valid = 1'b1; cmd_a = 32'h0000_0003; cmd_b = 32'hFFFF_FFFE; cmd_signed = 1'b1;
        tick();
        cmd_valid = 1'b0;
        checks++;
        if ({mul_valid, mul_data1, mul_data2, mul_signal} !== {1'b1, 32'hFFFF_FFFE, 32'h3, 1'b1}) begin
            errors++;
            $display("FAIL single_issue_ops: got v=%b d1=%h d2=%h s=%b expected 1/fffffffe/00000003/1",
                     mul_valid, mul_data1, mul_data2, mul_signal);
        end
        mul_ready = 1'b1;
        tick();
        mul_ready = 1'b0;
        checks++;
        if (outstanding !== 4'd1 || mul_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_after_issue: got outstanding=%0d mul_valid=%b expected 1/0",
                     outstanding, mul_valid);
        end
        repeat (2) tick();
        res_valid = 1'b1; res_data = 64'hFFFF_FFFF_FFFF_FFFA;
        tick();
        res_valid = 1'b0;
        checks++;
        if ({out_valid, out_res, out_tag, outstanding} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 4'd0, 4'd0}) begin
            errors++;
            $display("FAIL single_result: got v=%b res=%h tag=%0d outst=%0d expected 1/fffffffffffffffa/0/0",
                     out_valid, out_res, out_tag, outstanding);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_issue_backpressure();
        logic [31:0] av [4] = '{32'h2, 32'h10, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] bv [4] = '{32'h5, 32'h10, 32'h2, 32'hFFFF_FFFF};
        logic        sv [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [63:0] pv [4] = '{64'd10, 64'h100, 64'h0000_0001_FFFF_FFFE, 64'd1};
        mul_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_fill_ready[%0d]: got %b expected 1", k, cmd_ready);
            end
            cmd_valid = 1'b1; cmd_a = av[k]; cmd_b = bv[k]; cmd_signed = sv[k];
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_full: got cmd_ready=%b expected 0", cmd_ready);
        end
        for (int c = 0; c < 10; c++) begin
            checks++;
            if ({mul_valid, mul_data1, mul_data2} !== {1'b1, 32'h5, 32'h2}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d1=%h d2=%h expected 1/00000005/00000002",
                         c, mul_valid, mul_data1, mul_data2);
            end
            tick();
        end
        mul_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            // first release cycle also offers a push that must be refused while full
            cmd_valid = (k == 0); cmd_a = 32'hDEAD_BEEF; cmd_b = 32'h1; cmd_signed = 1'b0;
            if (k == 0) begin
                checks++;
                if (cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_push_pop_full: got cmd_ready=%b expected 0", cmd_ready);
                end
            end
            checks++;
            if ({mul_valid, mul_data2, mul_data1, mul_signal} !== {1'b1, av[k], bv[k], sv[k]}) begin
                errors++;
                $display("FAIL bp_release[%0d]: got v=%b d2=%h d1=%h s=%b expected 1/%h/%h/%b",
                         k, mul_valid, mul_data2, mul_data1, mul_signal, av[k], bv[k], sv[k]);
            end
            res_valid = (k >= 1);
            res_data  = (k >= 1) ? pv[(k >= 1) ? k-1 : 0] : 64'd0;
            tick();
            if (k >= 1) begin
                checks++;
                if ({out_valid, out_res, out_tag} !== {1'b1, pv[k-1], TAG_W'(k)}) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: got v=%b res=%h tag=%0d expected 1/%h/%0d",
                             k, out_valid, out_res, out_tag, pv[k-1], k);
                end
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (mul_valid !== 1'b0 || outstanding !== 4'd1) begin
            errors++;
            $display("FAIL bp_drained: got mul_valid=%b outstanding=%0d expected 0/1",
                     mul_valid, outstanding);
        end
        res_valid = 1'b1; res_data = pv[3];
        tick();
        res_valid = 1'b0;
        checks++;
        if ({out_res, out_tag, outstanding} !== {pv[3], 4'd4, 4'd0}) begin
            errors++;
            $display("FAIL bp_last_result: got res=%h tag=%0d outst=%0d expected %h/4/0",
                     out_res, out_tag, outstanding, pv[3]);
        end
        mul_ready = 1'b0;
    endtask

    task automatic test_outstanding_cap();
        logic [31:0] av [3] = '{32'h7, 32'hFFFF_FFF9, 32'h0001_86A0};
        logic [31:0] bv [3] = '{32'h6, 32'h6, 32'h0001_86A0};
        logic        sv [3] = '{1'b0, 1'b1, 1'b0};
        logic [63:0] pv [3] = '{64'h2A, 64'hFFFF_FFFF_FFFF_FFD6, 64'h2_540B_E400};
        int base;
        base = issue_cnt;
        mul_ready = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_a = av[k]; cmd_b = bv[k]; cmd_signed = sv[k];
            tick();
        end
        cmd_valid = 1'b0;
        repeat (3) tick();
        checks++;
        if ((issue_cnt - base) !== 2 || mul_valid !== 1'b0 || outstanding !== 4'd2) begin
            errors++;
            $display("FAIL cap_block: got issues=%0d mul_valid=%b outst=%0d expected 2/0/2",
                     issue_cnt - base, mul_valid, outstanding);
        end
        for (int k = 0; k < 3; k++) begin
            res_valid = 1'b1; res_data = pv[k];
            tick();
            checks++;
            if ({out_valid, out_res, out_tag} !== {1'b1, pv[k], TAG_W'(5 + k)}) begin
                errors++;
                $display("FAIL cap_result[%0d]: got v=%b res=%h tag=%0d expected 1/%h/%0d",
                         k, out_valid, out_res, out_tag, pv[k], 5 + k);
            end
            if (k == 0) begin
                checks++;
                if (mul_valid !== 1'b1 || mul_data2 !== av[2] || outstanding !== 4'd1) begin
                    errors++;
                    $display("FAIL cap_reassert: got v=%b d2=%h outst=%0d expected 1/%h/1",
                             mul_valid, mul_data2, outstanding, av[2]);
                end
            end
        end
        res_valid = 1'b0;
        checks++;
        if ((issue_cnt - base) !== 3 || outstanding !== 4'd0) begin
            errors++;
            $display("FAIL cap_total: got issues=%0d outst=%0d expected 3/0",
                     issue_cnt - base, outstanding);
        end
        mul_ready = 1'b0;
    endtask

    task automatic test_output_backpressure();
        mul_ready = 1'b1; out_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 32'h9; cmd_b = 32'h9; cmd_signed = 1'b0;
        tick();
        cmd_a = 32'h8000_0000; cmd_b = 32'h2; cmd_signed = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        mul_ready = 1'b0; out_ready = 1'b0;
        res_valid = 1'b1; res_data = 64'h51;
        tick();
        res_data = 64'hFFFF_FFFF_0000_0000;
        repeat (3) tick();
        checks++;
        if ({res_ready, out_valid, out_res, out_tag, outstanding} !== {1'b0, 1'b1, 64'h51, 4'd8, 4'd1}) begin
            errors++;
            $display("FAIL obp_hold: got rr=%b v=%b res=%h tag=%0d outst=%0d expected 0/1/51/8/1",
                     res_ready, out_valid, out_res, out_tag, outstanding);
        end
        out_ready = 1'b1;
        tick();
        res_valid = 1'b0;
        checks++;
        if ({out_valid, out_res, out_tag, outstanding} !== {1'b1, 64'hFFFF_FFFF_0000_0000, 4'd9, 4'd0}) begin
            errors++;
            $display("FAIL obp_second: got v=%b res=%h tag=%0d outst=%0d expected 1/ffffffff00000000/9/0",
                     out_valid, out_res, out_tag, outstanding);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL obp_drain: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_tag_wrap();
        logic [31:0] av [20];
        logic [31:0] bv [20];
        logic        sv [20];
        logic [63:0] model_q [$];
        logic [63:0] issued;
        logic        push_hs, issue_hs, res_hs;
        int pushed = 0, retired = 0, cyc = 0;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            av[i] = $urandom; bv[i] = $urandom; sv[i] = (i % 2 == 1);
        end
        mul_ready = 1'b1; out_ready = 1'b1;
        while (retired < 20 && cyc < 60) begin
            cmd_valid = (pushed < 20);
            if (pushed < 20) begin
                cmd_a = av[pushed]; cmd_b = bv[pushed]; cmd_signed = sv[pushed];
            end
            res_valid = (model_q.size() > 0);
            res_data  = (model_q.size() > 0) ? model_q[0] : 64'd0;
            push_hs   = cmd_valid && cmd_ready;
            issue_hs  = mul_valid && mul_ready;
            res_hs    = res_valid && res_ready;
            issued    = prod(mul_data2, mul_data1, mul_signal);
            tick();
            cyc++;
            if (push_hs) pushed++;
            if (res_hs) begin
                void'(model_q.pop_front());
                checks++;
                if ({out_valid, out_res, out_tag} !==
                    {1'b1, prod(av[retired], bv[retired], sv[retired]), TAG_W'(retired)}) begin
                    errors++;
                    $display("FAIL wrap_result[%0d]: got v=%b res=%h tag=%0d expected 1/%h/%0d",
                             retired, out_valid, out_res, out_tag,
                             prod(av[retired], bv[retired], sv[retired]), retired % 16);
                end
                retired++;
            end
            if (issue_hs) model_q.push_back(issued);
        end
        cmd_valid = 1'b0; res_valid = 1'b0; mul_ready = 1'b0;
        checks++;
        if (retired !== 20 || cyc !== 22) begin
            errors++;
            $display("FAIL wrap_throughput: got retired=%0d cycles=%0d expected 20/22", retired, cyc);
        end
    endtask

    task automatic test_reset_mid_stream();
        mul_ready = 1'b1; out_ready = 1'b1;
        cmd_valid = 1'b1; cmd_a = 32'h3; cmd_b = 32'h3; cmd_signed = 1'b0;
        tick();
        cmd_a = 32'h4;
        tick();
        cmd_valid = 1'b0;
        tick();
        mul_ready = 1'b0; out_ready = 1'b0;
        res_valid = 1'b1; res_data = 64'h9;
        tick();
        res_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1; cmd_a = 32'h100 + k; cmd_b = 32'h2; cmd_signed = 1'b0;
            tick();
        end
        cmd_valid = 1'b0;
        checks++;
        if ({outstanding, mul_valid, out_valid, cmd_ready} !== {4'd1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_pre_state: got outst=%0d mv=%b ov=%b cr=%b expected 1/1/1/1",
                     outstanding, mul_valid, out_valid, cmd_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, mul_valid, res_ready, out_valid, out_res, out_tag, outstanding, err} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 64'd0, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL mid_async_reset: got cr=%b mv=%b rr=%b ov=%b res=%h tag=%0d outst=%0d err=%b expected 1/0/1/0/0/0/0/0",
                     cmd_ready, mul_valid, res_ready, out_valid, out_res, out_tag, outstanding, err);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        checks++;
        if (mul_valid !== 1'b0 || outstanding !== 4'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_discarded: got mv=%b outst=%0d cr=%b expected 0/0/1",
                     mul_valid, outstanding, cmd_ready);
        end
        res_valid = 1'b1; res_data = 64'hBAD;
        tick();
        res_valid = 1'b0;
        checks++;
        if (err !== CHECK_EN) begin
            errors++;
            $display("FAIL spurious_err: got %b expected %b", err, CHECK_EN);
        end
        tick();
        checks++;
        if (err !== CHECK_EN) begin
            errors++;
            $display("FAIL sticky_err: got %b expected %b", err, CHECK_EN);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_signed = 1'b0;
        mul_ready = 1'b0; res_valid = 1'b0; res_data = '0; out_ready = 1'b1;
        test_reset();
        test_single_op();
        test_issue_backpressure();
        test_outstanding_cap();
        test_output_backpressure();
        test_tag_wrap();
        test_reset_mid_stream();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
